// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// The master side is fetch + decode; the queue itself is the slave.
interface inst_queue_if #(
    parameter int WORD_SIZE = 32,
    parameter int BYTE_SIZE = 32,
    parameter int ISSUE     = 2
);
    localparam int CW = $clog2(ISSUE + 1);

    logic                     flush;
    logic                     in_valid;
    logic [CW-1:0]            in_count;
    logic [BYTE_SIZE-1:0]     in_pc;
    logic [ISSUE*WORD_SIZE-1:0] in_inst;
    logic                     in_ready;
    logic [CW-1:0]            out_count;
    logic [ISSUE*WORD_SIZE-1:0] out_inst;
    logic [ISSUE*BYTE_SIZE-1:0] out_pc;
    logic [CW-1:0]            out_take;
    logic                     empty;
    logic                     full;

    modport master (
        output flush, in_valid, in_count, in_pc, in_inst, out_take,
        input  in_ready, out_count, out_inst, out_pc, empty, full
    );

    modport slave (
        input  flush, in_valid, in_count, in_pc, in_inst, out_take,
        output in_ready, out_count, out_inst, out_pc, empty, full
    );
endinterface

// File: rtl/inst_queue.sv
// Multi-issue circular instruction queue: up to ISSUE words in and out per cycle,
// each stored with its own PC; flush drops every entry.
module inst_queue #(
    parameter int WORD_SIZE = 32,
    parameter int BYTE_SIZE = 32,
    parameter int ISSUE     = 2,
    parameter int DEPTH     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_queue_if.slave   bus
);
    localparam int CW = $clog2(ISSUE + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [WORD_SIZE-1:0] inst_mem_q [DEPTH];
    logic [WORD_SIZE-1:0] inst_mem_d [DEPTH];
    logic [BYTE_SIZE-1:0] pc_mem_q   [DEPTH];
    logic [BYTE_SIZE-1:0] pc_mem_d   [DEPTH];
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [OW-1:0]        occ_q, occ_d;

    logic [CW-1:0]        enq_cnt;
    logic [CW-1:0]        taken;
    logic                 stop;
    logic                 enq;
    logic [PW-1:0]        widx;

    // Admission is based on registered occupancy only, so a dequeue in the
    // same cycle never frees room for the incoming group.
    assign bus.in_ready  = (occ_q <= OW'(DEPTH - ISSUE));
    assign bus.empty     = (occ_q == '0);
    assign bus.full      = (occ_q == OW'(DEPTH));
    assign bus.out_count = (occ_q >= OW'(ISSUE)) ? CW'(ISSUE) : occ_q[CW-1:0];

    assign enq   = bus.in_valid && bus.in_ready && !bus.flush;
    assign taken = (bus.out_take > bus.out_count) ? bus.out_count : bus.out_take;

    // A group ends at in_count or at the first all-zero word, whichever is first.
    always_comb begin
        enq_cnt = '0;
        stop    = 1'b0;
        for (int i = 0; i < ISSUE; i++) begin
            if (!stop && (CW'(i) < bus.in_count) &&
                (bus.in_inst[i*WORD_SIZE +: WORD_SIZE] != '0)) begin
                enq_cnt = CW'(i + 1);
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        widx       = '0;
        if (bus.flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            for (int i = 0; i < ISSUE; i++) begin
                if (enq && (CW'(i) < enq_cnt)) begin
                    widx             = tail_q + PW'(i);
                    inst_mem_d[widx] = bus.in_inst[i*WORD_SIZE +: WORD_SIZE];
                    pc_mem_d[widx]   = bus.in_pc + BYTE_SIZE'(4 * i);
                end
            end
            if (enq) begin
                tail_d = tail_q + PW'(enq_cnt);
            end
            head_d = head_q + PW'(taken);
            occ_d  = occ_q + (enq ? OW'(enq_cnt) : OW'(0)) - OW'(taken);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

    generate
        for (genvar gi = 0; gi < ISSUE; gi++) begin : g_out
            logic [PW-1:0] ridx;
            logic          live;
            assign ridx = head_q + PW'(gi);
            assign live = (CW'(gi) < bus.out_count);
            assign bus.out_inst[gi*WORD_SIZE +: WORD_SIZE] = live ? inst_mem_q[ridx] : '0;
            assign bus.out_pc[gi*BYTE_SIZE +: BYTE_SIZE]   = live ? pc_mem_q[ridx]   : '0;
        end
    endgenerate
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (ISSUE=2, DEPTH=8) with hand-computed expectations.
module tb_inst_queue;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    inst_queue_if #(.WORD_SIZE(32), .BYTE_SIZE(32), .ISSUE(2)) bus ();

    inst_queue #(.WORD_SIZE(32), .BYTE_SIZE(32), .ISSUE(2), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fw(input int n);
        return 32'hC000_0000 | 32'(n);
    endfunction

    function automatic logic [31:0] fpc(input int n);
        return 32'h1000 + 32'(4 * n);
    endfunction

    task automatic drive(input logic v, input logic [1:0] cnt, input logic [31:0] pc,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [1:0] take, input logic fl);
        bus.in_valid = v;
        bus.in_count = cnt;
        bus.in_pc    = pc;
        bus.in_inst  = {w1, w0};
        bus.out_take = take;
        bus.flush    = fl;
        if (v || take != 0 || fl)
            $display("step: valid=%0d count=%0d pc=%h w0=%h w1=%h take=%0d flush=%0d",
                     v, cnt, pc, w0, w1, take, fl);
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset held two cycles with a valid group present
        rst_n = 1'b0;
        drive(1'b1, 2'd2, 32'h100, 32'h11, 32'h22, 2'd0, 1'b0);
        tick();
        tick();
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_count", 64'(bus.out_count), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_inst", bus.out_inst, 64'd0);
        chk("rst_pc", bus.out_pc, 64'd0);
        rst_n = 1'b1;
        idle();
        tick();
        chk("rst_still_empty", 64'(bus.empty), 64'd1);

        // Basic enqueue then full dequeue
        drive(1'b1, 2'd2, 32'h100, 32'h00A00093, 32'h00B00113, 2'd0, 1'b0);
        tick();
        idle();
        chk("basic_count", 64'(bus.out_count), 64'd2);
        chk("basic_inst", bus.out_inst, {32'h00B00113, 32'h00A00093});
        chk("basic_pc", bus.out_pc, {32'h104, 32'h100});
        chk("basic_empty", 64'(bus.empty), 64'd0);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0);
        tick();
        idle();
        chk("basic_drain_empty", 64'(bus.empty), 64'd1);
        chk("basic_drain_count", 64'(bus.out_count), 64'd0);

        // Zero word terminates the group
        drive(1'b1, 2'd2, 32'h200, 32'h00100093, 32'h0, 2'd0, 1'b0);
        tick();
        idle();
        chk("zterm_count", 64'(bus.out_count), 64'd1);
        chk("zterm_inst", bus.out_inst, {32'h0, 32'h00100093});
        chk("zterm_pc", bus.out_pc, {32'h0, 32'h200});
        drive(1'b1, 2'd2, 32'h300, 32'h0, 32'h1234, 2'd1, 1'b0);
        tick();
        idle();
        chk("zslot0_empty", 64'(bus.empty), 64'd1);

        // Fill from head=tail=3 so the run wraps through index 7 -> 0
        for (int g = 0; g < 4; g++) begin
            drive(1'b1, 2'd2, fpc(2 * g), fw(2 * g), fw(2 * g + 1), 2'd0, 1'b0);
            tick();
            if (g == 2) chk("fill_occ6_ready", 64'(bus.in_ready), 64'd1);
        end
        idle();
        chk("fill_full", 64'(bus.full), 64'd1);
        chk("fill_ready", 64'(bus.in_ready), 64'd0);
        chk("fill_count", 64'(bus.out_count), 64'd2);
        drive(1'b1, 2'd2, 32'h2000, 32'hDEAD0001, 32'hDEAD0002, 2'd0, 1'b0);
        tick();
        idle();
        chk("full_ignore_full", 64'(bus.full), 64'd1);
        chk("full_ignore_head", 64'(bus.out_inst[31:0]), 64'(fw(0)));

        drive(1'b1, 2'd2, fpc(8), fw(8), fw(9), 2'd1, 1'b0);
        tick();
        chk("occ7_full", 64'(bus.full), 64'd0);
        chk("occ7_ready", 64'(bus.in_ready), 64'd0);
        chk("occ7_head", 64'(bus.out_inst[31:0]), 64'(fw(1)));
        tick();
        chk("occ6_ready", 64'(bus.in_ready), 64'd1);
        chk("occ6_head", 64'(bus.out_inst[31:0]), 64'(fw(2)));
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0);
        for (int s = 0; s < 4; s++) begin
            chk("wrap_count", 64'(bus.out_count), (s < 3) ? 64'd2 : 64'd1);
            chk("wrap_inst0", 64'(bus.out_inst[31:0]), 64'(fw(3 + 2 * s)));
            chk("wrap_pc0", 64'(bus.out_pc[31:0]), 64'(fpc(3 + 2 * s)));
            if (s < 3) chk("wrap_inst1", 64'(bus.out_inst[63:32]), 64'(fw(4 + 2 * s)));
            tick();
        end
        idle();
        chk("wrap_drained", 64'(bus.empty), 64'd1);

        // PC arithmetic wraps at 2^32
        drive(1'b1, 2'd2, 32'hFFFF_FFFC, 32'hA1, 32'hA2, 2'd0, 1'b0);
        tick();
        idle();
        chk("pcwrap_pc", bus.out_pc, {32'h0, 32'hFFFF_FFFC});
        drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0);
        tick();
        idle();

        // Flush at occ=5 with a same-cycle enqueue and take
        drive(1'b1, 2'd2, 32'h4000, 32'hF0, 32'hF1, 2'd0, 1'b0);
        tick();
        drive(1'b1, 2'd2, 32'h4008, 32'hF2, 32'hF3, 2'd0, 1'b0);
        tick();
        drive(1'b1, 2'd1, 32'h4010, 32'hF4, 32'hF5, 2'd0, 1'b0);
        tick();
        chk("preflush_count", 64'(bus.out_count), 64'd2);
        drive(1'b1, 2'd2, 32'h5000, 32'hBAD1, 32'hBAD2, 2'd2, 1'b1);
        tick();
        idle();
        chk("flush_empty", 64'(bus.empty), 64'd1);
        chk("flush_count", 64'(bus.out_count), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("flush_dropped", 64'(bus.empty), 64'd1);

        // Simultaneous enqueue and dequeue at occ=3
        drive(1'b1, 2'd2, 32'h6000, 32'h51, 32'h52, 2'd0, 1'b0);
        tick();
        drive(1'b1, 2'd1, 32'h6008, 32'h53, 32'h99, 2'd0, 1'b0);
        tick();
        drive(1'b1, 2'd2, 32'h600C, 32'h54, 32'h55, 2'd2, 1'b0);
        tick();
        idle();
        chk("simul_count", 64'(bus.out_count), 64'd2);
        chk("simul_inst", bus.out_inst, {32'h54, 32'h53});
        chk("simul_pc", bus.out_pc, {32'h600C, 32'h6008});
        drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0);
        tick();
        chk("simul_occ1_count", 64'(bus.out_count), 64'd1);
        chk("simul_occ1_inst", bus.out_inst, {32'h0, 32'h55});
        chk("simul_occ1_pc", bus.out_pc, {32'h0, 32'h6010});
        tick();
        chk("clamp_empty", 64'(bus.empty), 64'd1);
        tick();
        idle();
        chk("underflow_empty", 64'(bus.empty), 64'd1);
        chk("underflow_count", 64'(bus.out_count), 64'd0);
        drive(1'b1, 2'd1, 32'h7000, 32'h77, 32'h0, 2'd0, 1'b0);
        tick();
        idle();
        chk("post_count", 64'(bus.out_count), 64'd1);
        chk("post_pc", bus.out_pc, {32'h0, 32'h7000});
        chk("post_full", 64'(bus.full), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
